// File: rtl/vga_scan_out.sv
// 640x480 raster timing generator and registered pixel output stage for the ADV7123 VGA DAC.
// Scan coordinates feed the renderers; their merged RGB returns and is gated/registered with syncs.
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [7:0] r_data,
    input  logic [7:0] g_data,
    input  logic [7:0] b_data,
    output logic [9:0] x_cnt,
    output logic [9:0] y_cnt,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic in_window(input logic [9:0] c, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

    logic active_p0;
    logic x_wrap_p0;
    logic y_wrap_p0;

    always_comb begin
        active_p0 = (x_cnt < H_ACT) && (y_cnt < V_ACT);
        x_wrap_p0 = (x_cnt == H_LAST);
        y_wrap_p0 = (y_cnt == V_LAST);
    end

    // Stage p0 -> DAC: outputs describe the pre-update coordinate, one pix_en tick late
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (x_wrap_p0) begin
                    x_cnt <= '0;
                    y_cnt <= y_wrap_p0 ? '0 : y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
                vga_r       <= active_p0 ? r_data : 8'd0;
                vga_g       <= active_p0 ? g_data : 8'd0;
                vga_b       <= active_p0 ? b_data : 8'd0;
                vga_blank_n <= active_p0;
                vga_hs      <= !in_window(x_cnt, HS_BEGIN, HS_END);
                vga_vs      <= !in_window(y_cnt, VS_BEGIN, VS_END);
                frame_start <= x_wrap_p0 && y_wrap_p0;
            end
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out: full 800-pixel line timing, with a shortened vertical
// frame (12 lines) so multi-frame sync and frame_start checks stay within a short run.
module tb_vga_scan_out;

    localparam int TVA = 6;
    localparam int TVF = 2;
    localparam int TVS = 2;
    localparam int TVB = 2;
    localparam int HT  = 800;
    localparam int VT  = TVA + TVF + TVS + TVB;
    localparam int FT  = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [7:0] r_data = 8'd0;
    logic [7:0] g_data = 8'd0;
    logic [7:0] b_data = 8'd0;
    logic [9:0] x_cnt;
    logic [9:0] y_cnt;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       frame_start;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  fast = 1'b0;

    vga_scan_out #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(TVA), .V_FP(TVF), .V_SYNC(TVS), .V_BP(TVB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .r_data(r_data), .g_data(g_data), .b_data(b_data),
        .x_cnt(x_cnt), .y_cnt(y_cnt),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // One pixel tick: pix_en high for one clk, then low for one clk unless running at full rate.
    task automatic step();
        pix_en = 1'b1;
        @(posedge clk); #1;
        if (!fast) begin
            pix_en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({x_cnt, y_cnt} !== 20'd0) begin
            n_fail++; $display("FAIL %s counters: got x=%0d y=%0d, want 0,0", tag, x_cnt, y_cnt);
        end
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 24'd0) begin
            n_fail++; $display("FAIL %s rgb: got %h%h%h, want 000000", tag, vga_r, vga_g, vga_b);
        end
        n_checks++;
        if ({vga_hs, vga_vs, vga_blank_n, frame_start, vga_sync_n} !== 5'b11000) begin
            n_fail++;
            $display("FAIL %s ctrl hs/vs/blank_n/fs/sync_n: got %b%b%b%b%b, want 11000",
                     tag, vga_hs, vga_vs, vga_blank_n, frame_start, vga_sync_n);
        end
    endtask

    task automatic test_reset();
        fast = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_reset_values("reset");
        r_data = 8'h12; g_data = 8'h34; b_data = 8'h56;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (x_cnt !== 10'd1 || y_cnt !== 10'd0) begin
            n_fail++; $display("FAIL first_tick_xy: got x=%0d y=%0d, want 1,0", x_cnt, y_cnt);
        end
        n_checks++;
        if ({vga_r, vga_g, vga_b, vga_blank_n, vga_hs, vga_vs} !== {24'h123456, 3'b111}) begin
            n_fail++;
            $display("FAIL first_tick_out: got rgb=%h%h%h blank_n=%b hs=%b vs=%b, want 123456 1 1 1",
                     vga_r, vga_g, vga_b, vga_blank_n, vga_hs, vga_vs);
        end
    endtask

    task automatic test_line();
        int   guard;
        int   r_on, r_first_off, hs_low, hs_first, blank_on, x_err, g_err;
        logic [9:0] y0;
        r_data = 8'hFF; b_data = 8'h00;
        guard = 0;
        while (x_cnt !== 10'd0 && guard < HT + 2) begin step(); guard++; end
        n_checks++;
        if (x_cnt !== 10'd0) begin
            n_fail++; $display("FAIL line_sync: got x=%0d, want 0", x_cnt);
        end
        y0 = y_cnt;
        r_on = 0; r_first_off = -1; hs_low = 0; hs_first = -1; blank_on = 0; x_err = 0; g_err = 0;
        for (int k = 0; k < HT; k++) begin
            if (x_cnt !== 10'(k)) x_err++;
            g_data = x_cnt[7:0];
            step();
            if (vga_r === 8'hFF) r_on++;
            else if (r_first_off < 0) r_first_off = k;
            if (vga_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            if (vga_blank_n === 1'b1) blank_on++;
            if (k < 640 && vga_g !== 8'(k)) g_err++;
            if (k >= 640 && vga_g !== 8'd0) g_err++;
        end
        n_checks++;
        if (x_err != 0) begin n_fail++; $display("FAIL line_x_seq: got %0d bad counts, want 0", x_err); end
        n_checks++;
        if (r_on != 640 || r_first_off != 640) begin
            n_fail++; $display("FAIL line_red: got on=%0d first_off=%0d, want 640 640", r_on, r_first_off);
        end
        n_checks++;
        if (hs_low != 96 || hs_first != 656) begin
            n_fail++; $display("FAIL line_hs: got low=%0d first=%0d, want 96 656", hs_low, hs_first);
        end
        n_checks++;
        if (blank_on != 640) begin n_fail++; $display("FAIL line_blank: got %0d, want 640", blank_on); end
        n_checks++;
        if (g_err != 0) begin n_fail++; $display("FAIL line_green_align: got %0d errors, want 0", g_err); end
        n_checks++;
        if (x_cnt !== 10'd0 || y_cnt !== y0 + 10'd1) begin
            n_fail++; $display("FAIL line_period: got x=%0d y=%0d, want 0 %0d", x_cnt, y_cnt, y0 + 10'd1);
        end
    endtask

    task automatic test_pause();
        int guard, diffs, fs_seen;
        logic [9:0] ys;
        logic [27:0] snap;
        guard = 0;
        while (x_cnt !== 10'd300 && guard < HT + 2) begin step(); guard++; end
        ys = y_cnt;
        snap = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start};
        diffs = 0; fs_seen = 0;
        pix_en = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(posedge clk); #1;
            if (x_cnt !== 10'd300 || y_cnt !== ys) diffs++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start} !== snap) diffs++;
            if (frame_start !== 1'b0) fs_seen++;
        end
        n_checks++;
        if (diffs != 0 || fs_seen != 0) begin
            n_fail++; $display("FAIL pause_hold: got %0d changes, %0d frame_start, want 0 0", diffs, fs_seen);
        end
        step();
        n_checks++;
        if (x_cnt !== 10'd301) begin n_fail++; $display("FAIL pause_resume: got x=%0d, want 301", x_cnt); end
    endtask

    task automatic test_vsync();
        int guard, xy_err, vs_err, blank_err, vs_low, vs_first;
        int ex, ey;
        fast = 1'b1;
        guard = 0;
        while (frame_start !== 1'b1 && guard < FT + 10) begin step(); guard++; end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++; $display("FAIL vsync_sync: got no frame_start within %0d ticks, want one", FT + 10);
        end
        xy_err = 0; vs_err = 0; blank_err = 0; vs_low = 0; vs_first = -1;
        for (int t = 0; t < 2 * FT; t++) begin
            ex = t % HT;
            ey = (t / HT) % VT;
            if (x_cnt !== 10'(ex) || y_cnt !== 10'(ey)) xy_err++;
            step();
            if (vga_vs === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = t;
            end
            if (vga_vs !== !(ey >= TVA + TVF && ey < TVA + TVF + TVS)) vs_err++;
            if (vga_blank_n !== (ex < 640 && ey < TVA)) blank_err++;
        end
        n_checks++;
        if (xy_err != 0) begin n_fail++; $display("FAIL frame_counters: got %0d bad, want 0", xy_err); end
        n_checks++;
        if (vs_low != 2 * TVS * HT || vs_first != (TVA + TVF) * HT) begin
            n_fail++;
            $display("FAIL frame_vs: got low=%0d first=%0d, want %0d %0d",
                     vs_low, vs_first, 2 * TVS * HT, (TVA + TVF) * HT);
        end
        n_checks++;
        if (vs_err != 0 || blank_err != 0) begin
            n_fail++; $display("FAIL frame_vs_blank_shape: got vs_err=%0d blank_err=%0d, want 0 0", vs_err, blank_err);
        end
    endtask

    task automatic test_frame_start();
        int pulses, p0, p1, xy_err, wide;
        bit prev;
        pulses = 0; p0 = -1; p1 = -1; xy_err = 0; wide = 0; prev = 1'b0;
        for (int t = 0; t < 2 * FT; t++) begin
            step();
            if (frame_start === 1'b1) begin
                if (prev) wide++;
                pulses++;
                if (p0 < 0) p0 = t; else if (p1 < 0) p1 = t;
                if (x_cnt !== 10'd0 || y_cnt !== 10'd0) xy_err++;
            end
            prev = (frame_start === 1'b1);
        end
        n_checks++;
        if (pulses != 2 || wide != 0) begin
            n_fail++; $display("FAIL fs_count: got pulses=%0d wide=%0d, want 2 0", pulses, wide);
        end
        n_checks++;
        if (p0 != FT - 1 || p1 - p0 != FT) begin
            n_fail++; $display("FAIL fs_period: got first=%0d gap=%0d, want %0d %0d", p0, p1 - p0, FT - 1, FT);
        end
        n_checks++;
        if (xy_err != 0) begin n_fail++; $display("FAIL fs_at_origin: got %0d off-origin, want 0", xy_err); end
    endtask

    task automatic test_async_reset();
        int guard, n;
        bit first_ok;
        fast = 1'b1;
        guard = 0;
        while (!(x_cnt === 10'd700 && y_cnt === 10'd4) && guard < FT + 10) begin step(); guard++; end
        n_checks++;
        if (x_cnt !== 10'd700 || y_cnt !== 10'd4) begin
            n_fail++; $display("FAIL areset_pos: got x=%0d y=%0d, want 700 4", x_cnt, y_cnt);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("areset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0; first_ok = 1'b0;
        do begin
            step();
            n++;
            if (n == 1) first_ok = (x_cnt === 10'd1 && vga_blank_n === 1'b1);
        end while (frame_start !== 1'b1 && n < FT + 10);
        n_checks++;
        if (!first_ok) begin n_fail++; $display("FAIL areset_first_tick: got bad (0,0) output, want x=1 blank_n=1"); end
        n_checks++;
        if (n != FT || frame_start !== 1'b1) begin
            n_fail++; $display("FAIL areset_fs: got ticks=%0d fs=%b, want %0d 1", n, frame_start, FT);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_pause();
        test_vsync();
        test_frame_start();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
